johnson_phase_tracker: RTL
==========================

Name: johnson_phase_tracker

Overview:
Downstream consumer of the twisted-ring (Johnson) counter. Samples the counter's code each cycle and decodes it into a binary phase index and a one-hot phase strobe. It checks that each code is legal and that consecutive codes follow the Johnson step. A lock state machine reports when the sequence is trustworthy, flags errors, and counts faults for the sequencing and control logic downstream.

Parameters:
WIDTH, 4, Johnson code width; the sequence has 2*WIDTH states
LOCK_STEPS, 4, consecutive correct steps required to reach lock (1..15)
ECW, 8, width of the saturating error counter
PW (localparam), $clog2(2*WIDTH), phase index width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset; synchronous, active-high
jc_in  in  WIDTH  Johnson code from the upstream counter
jc_valid  in  1  jc_in is meaningful this cycle
err_clr  in  1  clear err_cnt
phase  out  PW  decoded phase index of the last accepted sample
phase_oh  out  2*WIDTH  one-hot of phase; all zero if the sample was illegal
phase_vld  out  1  phase/phase_oh were updated by a valid sample this cycle
illegal  out  1  last accepted sample was not a legal Johnson code
wrap  out  1  one-cycle pulse: locked and accepted phase == 0
locked  out  1  lock FSM is in LOCKED
err  out  1  one-cycle pulse: fault detected while LOCKED
err_cnt  out  ECW  saturating count of err pulses

Behaviour:
- All outputs are registered with 1-cycle latency. A sample taken at edge N is reflected in the outputs right after edge N.
- Reset (rst=1 at an edge): all outputs are 0, FSM=SEARCH, prev_valid=0, step_cnt=0, prev code=0. Reset mid-operation discards lock and the step history.
- Legality: a code is legal iff at most one index i in [0,WIDTH-2] has jc_in[i] != jc_in[i+1]. For WIDTH=4, the 8 legal codes are 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- Phase mapping, with p = popcount(jc_in):
  - MSB=1: phase = p.
  - MSB=0 and p=0: phase = 0.
  - MSB=0 and p>0: phase = 2*WIDTH - p.
  - For WIDTH=4: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
- Expected successor: next(c) = {~c[0], c[WIDTH-1:1]}. step_ok = prev_valid && legal && (jc_in == next(prev)).
- jc_valid=0: no state change. prev code is retained. phase and phase_oh hold their values. phase_vld, wrap and err are 0. Gaps of any length are allowed, and the next valid code must be next(prev).
- jc_valid=1: prev is set to jc_in and prev_valid to 1. phase_vld=1. illegal is set to !legal. phase_oh is set to (1<<phase) when legal, else 0.
- The first valid sample after reset, or after leaving LOCKED, seeds the history only; it is not checked for continuity.
- FSM states: SEARCH, LOCKED.
  - SEARCH, valid sample:
    - step_ok: step_cnt += 1. When step_cnt reaches LOCK_STEPS, go to LOCKED and clear step_cnt; locked=1 on that same edge.
    - Otherwise: step_cnt=0.
    - err is never asserted in SEARCH.
  - LOCKED, valid sample:
    - !step_ok (illegal or wrong step): err=1 for one cycle, locked=0, go to SEARCH, step_cnt=0. The faulty sample becomes prev, with prev_valid=1.
    - Otherwise: stay in LOCKED.
- wrap = 1 iff the FSM is LOCKED after the edge, the sample is valid and legal, and phase==0.
- err_cnt increments on each err pulse and saturates at 2^ECW-1. err_clr forces err_cnt=0 and wins over a simultaneous increment.

Decomposition:
- Shared package johnson_pkg:
  - state enum {SEARCH, LOCKED}.
  - Functions jc_next(code), jc_legal(code), jc_phase(code), parameterised via WIDTH-sized arguments.
- One combinational sub-module, johnson_decode (jc_in → legal, phase, phase_oh). It is reusable by other consumers of the counter.
- The tracker top holds the history register, step_cnt, FSM and err_cnt.

Test Plan:
1. rst for 2 cycles, then continuous valid 0001, 0000, 1000, 1100, 1110, 1111 → phase 7, 0, 1, 2, 3, 4. locked rises after the 5th sample (1110). wrap stays 0 at the first phase 0. err=0 throughout.
2. After lock, run 16 further consecutive codes → phase_oh == 1<<phase every cycle. wrap pulses exactly at each phase 0, 8 cycles apart. err_cnt stays 0.
3. Locked, inject 0101 → illegal=1, phase_oh=0, err=1 for one cycle, locked=0, err_cnt=1. Then resume with 1010? No: resume at legal 0010? No. Resume with any legal code c followed by next(c) repeated → locked again after LOCK_STEPS good steps.
4. Locked at 1000, then present 1110 (skipped step) → illegal=0, phase=3, err=1, locked=0, err_cnt increments.
5. Locked at 1100, jc_valid=0 for 3 cycles with jc_in=0101, then valid 1110 → phase_vld=0 and phase=2 held during the gap; no err; locked stays 1; phase=3 after resume.
6. ECW=2: force 4 faults → err_cnt reads 1, 2, 3, 3 (saturates). Then assert err_clr in the same cycle as a fault → err_cnt=0 and err=1.

Source files
------------

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson code helpers and lock FSM encodings
package johnson_pkg;

  localparam int JC_MAX_W = 32;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Helpers take a max-width code plus the live width so any consumer width fits.
  function automatic logic [JC_MAX_W-1:0] jc_next(input logic [JC_MAX_W-1:0] code, input int w);
    logic [JC_MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if (i < w - 1) n[i] = code[i+1];
    end
    n[w-1] = ~code[0];
    return n;
  endfunction

  function automatic logic jc_legal(input logic [JC_MAX_W-1:0] code, input int w);
    int t;
    t = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if (i < w - 1 && code[i] != code[i+1]) t++;
    end
    return (t <= 1);
  endfunction

  function automatic int jc_phase(input logic [JC_MAX_W-1:0] code, input int w);
    int p;
    p = 0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i < w && code[i]) p++;
    end
    if (code[w-1]) return p;
    else if (p == 0) return 0;
    else return 2 * w - p;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson code to phase index / one-hot decoder
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW   = $clog2(2 * WIDTH),
  localparam int OHW  = 2 * WIDTH
) (
  input  logic [WIDTH-1:0] jc_in,
  output logic             legal,
  output logic [PW-1:0]    phase,
  output logic [OHW-1:0]   phase_oh
);

  always_comb begin
    legal    = jc_legal(JC_MAX_W'(jc_in), WIDTH);
    phase    = PW'(jc_phase(JC_MAX_W'(jc_in), WIDTH));
    phase_oh = legal ? (OHW'(1) << phase) : '0;
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// rtl/johnson_phase_tracker.sv - Johnson counter sequence checker with lock FSM and fault counter
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 4,
  parameter int ECW        = 8,
  localparam int PW        = $clog2(2 * WIDTH),
  localparam int OHW       = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             jc_valid,
  input  logic             err_clr,
  output logic [PW-1:0]    phase,
  output logic [OHW-1:0]   phase_oh,
  output logic             phase_vld,
  output logic             illegal,
  output logic             wrap,
  output logic             locked,
  output logic             err,
  output logic [ECW-1:0]   err_cnt
);

  logic             dec_legal;
  logic [PW-1:0]    dec_phase;
  logic [OHW-1:0]   dec_oh;

  logic [0:0]       state_q, state_d;
  logic [3:0]       step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_valid_q;
  logic [PW-1:0]    phase_q;
  logic [OHW-1:0]   phase_oh_q;
  logic             phase_vld_q, illegal_q, wrap_q, err_q;
  logic             err_d, wrap_d, step_ok;
  logic [ECW-1:0]   err_cnt_q;
  logic [WIDTH-1:0] next_exp;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .jc_in    (jc_in),
    .legal    (dec_legal),
    .phase    (dec_phase),
    .phase_oh (dec_oh)
  );

  assign next_exp = WIDTH'(jc_next(JC_MAX_W'(prev_q), WIDTH));
  assign step_ok  = prev_valid_q && dec_legal && (jc_in == next_exp);

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    err_d      = 1'b0;
    if (jc_valid) begin
      if (state_q == SEARCH) begin
        if (step_ok) begin
          if (step_cnt_q + 4'd1 == 4'(LOCK_STEPS)) begin
            state_d    = LOCKED;
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + 4'd1;
          end
        end else begin
          step_cnt_d = '0;
        end
      end else if (!step_ok) begin
        err_d      = 1'b1;
        state_d    = SEARCH;
        step_cnt_d = '0;
      end
    end
    wrap_d = jc_valid && (state_d == LOCKED) && dec_legal && (dec_phase == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      step_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      phase_q      <= '0;
      phase_oh_q   <= '0;
      phase_vld_q  <= 1'b0;
      illegal_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      phase_vld_q <= jc_valid;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      // A faulty sample still becomes the history so recovery restarts from it.
      if (jc_valid) begin
        prev_q       <= jc_in;
        prev_valid_q <= 1'b1;
        phase_q      <= dec_phase;
        phase_oh_q   <= dec_oh;
        illegal_q    <= !dec_legal;
      end
      if (err_clr) err_cnt_q <= '0;
      else if (err_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign phase     = phase_q;
  assign phase_oh  = phase_oh_q;
  assign phase_vld = phase_vld_q;
  assign illegal   = illegal_q;
  assign wrap      = wrap_q;
  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule
